draw_rect: RTL and testbench

//   Pixel-pipeline stage directly downstream of the VGA timing generator
//   (800x600 active, 1056x628 total). It consumes the timing bus and an

---
 rtl/draw_rect_if.sv | 45 ++++
 rtl/draw_rect.sv | 130 +++++++++++++
 tb/tb_draw_rect.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/draw_rect_if.sv
`default_nettype none
// ============================================================================
//  Module   : draw_rect_if
//  Purpose  : VGA timing + pixel bus into and out of the rectangle overlay
//             stage, with the rectangle position request.
//  Revision : 1.0  initial release
// ============================================================================
interface draw_rect_if;
   // Timing and pixel stream from the upstream stage
   logic [10:0] hcount_in;
   logic        hsync_in;
   logic        hblnk_in;
   logic [10:0] vcount_in;
   logic        vsync_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   // Requested rectangle top-left corner
   logic [11:0] xpos;
   logic [11:0] ypos;
   // Delayed timing and composited pixel
   logic [10:0] hcount_out;
   logic        hsync_out;
   logic        hblnk_out;
   logic [10:0] vcount_out;
   logic        vsync_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   // Producer side (timing generator / bench)
   modport master (
      output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
             rgb_in, xpos, ypos,
      input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
             vblnk_out, rgb_out
   );

   // Overlay stage side
   modport slave (
      input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
             rgb_in, xpos, ypos,
      output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
             vblnk_out, rgb_out
   );
endinterface
`default_nettype wire

// File: rtl/draw_rect.sv
`default_nettype none
// ============================================================================
//  Module   : draw_rect
//  Purpose  : Overlays a solid, frame-synchronised rectangle on the VGA
//             pixel stream. Two-cycle pipeline; timing is delayed to stay
//             aligned with the composited colour.
//  Revision : 1.0  initial release
// ============================================================================
module draw_rect #(
   parameter int          RECT_W   = 64,
   parameter int          RECT_H   = 32,
   parameter logic [11:0] RECT_RGB = 12'hF80,
   parameter int          H_ACTIVE = 800,
   parameter int          V_ACTIVE = 600
) (
   input wire          pclk,
   input wire          rst,
   draw_rect_if.slave  io_vga
);

   // 13-bit constants so that position + size can never wrap
   localparam logic [12:0] c_RECT_W   = 13'(RECT_W);
   localparam logic [12:0] c_RECT_H   = 13'(RECT_H);
   localparam logic [12:0] c_H_ACTIVE = 13'(H_ACTIVE);
   localparam logic [12:0] c_V_ACTIVE = 13'(V_ACTIVE);

   // Latched position and vblank edge detector
   logic        r_vblnk_prev;
   logic [11:0] r_x;
   logic [11:0] r_y;

   // Stage 1
   logic [10:0] r_hcount_s1, r_vcount_s1;
   logic        r_hsync_s1, r_hblnk_s1, r_vsync_s1, r_vblnk_s1;
   logic [11:0] r_rgb_s1;
   logic        r_hit_s1;

   // Stage 2
   logic [10:0] r_hcount_s2, r_vcount_s2;
   logic        r_hsync_s2, r_hblnk_s2, r_vsync_s2, r_vblnk_s2;
   logic [11:0] r_rgb_s2;

   // Hit test on the current input pixel, all in 13-bit unsigned
   logic [12:0] w_h, w_v, w_x, w_y, w_x_end, w_y_end;
   logic        w_hit;

   assign w_h     = {2'b00, io_vga.hcount_in};
   assign w_v     = {2'b00, io_vga.vcount_in};
   assign w_x     = {1'b0, r_x};
   assign w_y     = {1'b0, r_y};
   assign w_x_end = w_x + c_RECT_W;
   assign w_y_end = w_y + c_RECT_H;
   assign w_hit   = (w_h >= w_x) && (w_h < w_x_end) &&
                    (w_v >= w_y) && (w_v < w_y_end) &&
                    (w_h < c_H_ACTIVE) && (w_v < c_V_ACTIVE);

   // Capture the requested position only on the rising edge of vblank
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_vblnk_prev <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
      end else begin
         r_vblnk_prev <= io_vga.vblnk_in;
         if (io_vga.vblnk_in && !r_vblnk_prev) begin
            r_x <= io_vga.xpos;
            r_y <= io_vga.ypos;
         end
      end
   end

   // Stage 1: register timing, upstream colour and the hit flag
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hcount_s1 <= '0;
         r_vcount_s1 <= '0;
         r_hsync_s1  <= 1'b0;
         r_hblnk_s1  <= 1'b0;
         r_vsync_s1  <= 1'b0;
         r_vblnk_s1  <= 1'b0;
         r_rgb_s1    <= '0;
         r_hit_s1    <= 1'b0;
      end else begin
         r_hcount_s1 <= io_vga.hcount_in;
         r_vcount_s1 <= io_vga.vcount_in;
         r_hsync_s1  <= io_vga.hsync_in;
         r_hblnk_s1  <= io_vga.hblnk_in;
         r_vsync_s1  <= io_vga.vsync_in;
         r_vblnk_s1  <= io_vga.vblnk_in;
         r_rgb_s1    <= io_vga.rgb_in;
         r_hit_s1    <= w_hit;
      end
   end

   // Stage 2: blanking forces black, then rectangle, then upstream pixel
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hcount_s2 <= '0;
         r_vcount_s2 <= '0;
         r_hsync_s2  <= 1'b0;
         r_hblnk_s2  <= 1'b0;
         r_vsync_s2  <= 1'b0;
         r_vblnk_s2  <= 1'b0;
         r_rgb_s2    <= '0;
      end else begin
         r_hcount_s2 <= r_hcount_s1;
         r_vcount_s2 <= r_vcount_s1;
         r_hsync_s2  <= r_hsync_s1;
         r_hblnk_s2  <= r_hblnk_s1;
         r_vsync_s2  <= r_vsync_s1;
         r_vblnk_s2  <= r_vblnk_s1;
         if (r_hblnk_s1 || r_vblnk_s1)
            r_rgb_s2 <= 12'h000;
         else if (r_hit_s1)
            r_rgb_s2 <= RECT_RGB;
         else
            r_rgb_s2 <= r_rgb_s1;
      end
   end

   assign io_vga.hcount_out = r_hcount_s2;
   assign io_vga.vcount_out = r_vcount_s2;
   assign io_vga.hsync_out  = r_hsync_s2;
   assign io_vga.hblnk_out  = r_hblnk_s2;
   assign io_vga.vsync_out  = r_vsync_s2;
   assign io_vga.vblnk_out  = r_vblnk_s2;
   assign io_vga.rgb_out    = r_rgb_s2;

endmodule
`default_nettype wire

// File: tb/tb_draw_rect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_rect
//  Purpose  : Directed self-checking bench for draw_rect (64x32, F80).
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_rect;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   draw_rect_if vif ();

   draw_rect #(
      .RECT_W   (64),
      .RECT_H   (32),
      .RECT_RGB (12'hF80),
      .H_ACTIVE (800),
      .V_ACTIVE (600)
   ) u_dut (
      .pclk   (pclk),
      .rst    (rst),
      .io_vga (vif.slave)
   );

   // 10 ns pixel clock
   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_in(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                         input logic hb, input logic vb);
      vif.hcount_in = h;
      vif.vcount_in = v;
      vif.rgb_in    = rgb;
      vif.hblnk_in  = hb;
      vif.vblnk_in  = vb;
      vif.hsync_in  = 1'b0;
      vif.vsync_in  = 1'b0;
   endtask

   // Present one pixel, hold it through the 2-cycle pipe and check colour
   task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                      input logic [11:0] rgb, input logic hb, input logic vb,
                      input logic [11:0] exp_rgb);
      set_in(h, v, rgb, hb, vb);
      tick();
      tick();
      chk(tag, {20'd0, vif.rgb_out}, {20'd0, exp_rgb});
   endtask

   // Generate a vblank rising edge with the given requested position
   task automatic vblank_edge(input logic [11:0] x, input logic [11:0] y);
      vif.xpos = x;
      vif.ypos = y;
      set_in(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
      tick();
      vif.vblnk_in = 1'b1;
      tick();
      vif.vblnk_in = 1'b0;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rgb"}, {20'd0, vif.rgb_out}, 32'd0);
      chk({tag, "_cnt"}, {10'd0, vif.hcount_out, vif.vcount_out}, 32'd0);
      chk({tag, "_flg"}, {28'd0, vif.hsync_out, vif.hblnk_out, vif.vsync_out, vif.vblnk_out}, 32'd0);
   endtask

   initial begin
      set_in(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
      vif.xpos = 12'd0;
      vif.ypos = 12'd0;

      // 1. Reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vif.hcount_in = 11'($urandom);
         vif.vcount_in = 11'($urandom);
         vif.rgb_in    = 12'($urandom);
         vif.hsync_in  = 1'($urandom);
         vif.hblnk_in  = 1'($urandom);
         vif.vsync_in  = 1'($urandom);
         vif.vblnk_in  = 1'($urandom);
         vif.xpos      = 12'($urandom);
         vif.ypos      = 12'($urandom);
         tick();
         chk_all_zero("reset");
      end
      vif.xpos = 12'd0;
      vif.ypos = 12'd0;
      set_in(11'd0, 11'd0, 12'h00F, 1'b0, 1'b0);
      rst = 1'b0;
      pix("rst_rect_00",   11'd0,  11'd0,  12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("rst_rect_63_31", 11'd63, 11'd31, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("rst_rect_64",   11'd64, 11'd0,  12'h00F, 1'b0, 1'b0, 12'h00F);

      // 2. Latency: one-cycle pulse on every timing input at cycle N
      set_in(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
      tick();
      tick();
      vif.hsync_in  = 1'b1;
      vif.vsync_in  = 1'b1;
      vif.hblnk_in  = 1'b1;
      vif.vblnk_in  = 1'b1;
      vif.hcount_in = 11'd123;
      vif.vcount_in = 11'd45;
      tick();
      set_in(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
      chk("lat_n1_flags", {28'd0, vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out}, 32'h0);
      chk("lat_n1_cnt",   {10'd0, vif.hcount_out, vif.vcount_out}, 32'd0);
      tick();
      chk("lat_n2_hsync", {31'd0, vif.hsync_out}, 32'd1);
      chk("lat_n2_vsync", {31'd0, vif.vsync_out}, 32'd1);
      chk("lat_n2_hblnk", {31'd0, vif.hblnk_out}, 32'd1);
      chk("lat_n2_vblnk", {31'd0, vif.vblnk_out}, 32'd1);
      chk("lat_n2_hcnt",  {21'd0, vif.hcount_out}, 32'd123);
      chk("lat_n2_vcnt",  {21'd0, vif.vcount_out}, 32'd45);
      tick();
      chk("lat_n3_flags", {28'd0, vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out}, 32'h0);
      chk("lat_n3_cnt",   {10'd0, vif.hcount_out, vif.vcount_out}, 32'd0);

      // 3. Rectangle at (100,50)
      vblank_edge(12'd100, 12'd50);
      pix("r100_in_tl",  11'd100, 11'd50, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("r100_left",   11'd99,  11'd50, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("r100_in_br",  11'd163, 11'd81, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("r100_right",  11'd164, 11'd81, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("r100_below",  11'd163, 11'd82, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("r100_above",  11'd100, 11'd49, 12'h00F, 1'b0, 1'b0, 12'h00F);

      // 4. Mid-frame position change is deferred to the next vblank edge
      vif.xpos = 12'd300;
      pix("mid_old_pos", 11'd100, 11'd50, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("mid_new_pos", 11'd300, 11'd50, 12'h00F, 1'b0, 1'b0, 12'h00F);
      vblank_edge(12'd300, 12'd50);
      pix("next_new_pos", 11'd300, 11'd50, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("next_old_pos", 11'd100, 11'd50, 12'h00F, 1'b0, 1'b0, 12'h00F);

      // 5. Clipping at the bottom-right corner
      vblank_edge(12'd780, 12'd590);
      pix("clip_tl",     11'd780, 11'd590, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("clip_br",     11'd799, 11'd599, 12'h00F, 1'b0, 1'b0, 12'hF80);
      pix("clip_left",   11'd779, 11'd590, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("clip_h800",   11'd800, 11'd595, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("clip_v600",   11'd790, 11'd600, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("clip_hblnk",  11'd800, 11'd595, 12'h00F, 1'b1, 1'b0, 12'h000);
      pix("nowrap_h",    11'd10,  11'd595, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("nowrap_v",    11'd790, 11'd10,  12'h00F, 1'b0, 1'b0, 12'h00F);
      // Off-screen request draws nothing
      vblank_edge(12'd800, 12'd10);
      pix("off_h800",    11'd800, 11'd10, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("off_h0",      11'd0,   11'd10, 12'h00F, 1'b0, 1'b0, 12'h00F);

      // 6. Blanking wins over everything
      vblank_edge(12'd380, 12'd290);
      pix("blank_h",     11'd50,  11'd50,  12'hFFF, 1'b1, 1'b0, 12'h000);
      pix("blank_v",     11'd50,  11'd50,  12'hFFF, 1'b0, 1'b1, 12'h000);
      pix("blank_in_rect", 11'd400, 11'd300, 12'hFFF, 1'b1, 1'b0, 12'h000);
      // Mid-frame reset at (400,300) with the rectangle covering it
      vblank_edge(12'd380, 12'd290);
      pix("pre_rst_hit", 11'd400, 11'd300, 12'h00F, 1'b0, 1'b0, 12'hF80);
      vif.hsync_in = 1'b1;
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      vif.hsync_in = 1'b0;
      rst = 1'b0;
      pix("post_rst_old", 11'd400, 11'd300, 12'h00F, 1'b0, 1'b0, 12'h00F);
      pix("post_rst_00",  11'd10,  11'd10,  12'h00F, 1'b0, 1'b0, 12'hF80);
      chk("post_rst_hcnt", {21'd0, vif.hcount_out}, 32'd10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net: the directed sequence is short, so this never fires normally
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
